// File: rtl/clock_base_pkg.sv
// Shared constants for the shift-register LED demo.
package clock_base_pkg;

    localparam int LED_W = 8;
    localparam int DIV_COUNT_DEF = 25_000_000;
    localparam logic [LED_W-1:0] LED_INIT_DEF = 8'h01;

endpackage

// File: rtl/clock_base_tick_gen.sv
// Prescaler: one-cycle tick every DIV_COUNT clocks.
module tick_gen
    import clock_base_pkg::*;
#(
    parameter int DIV_COUNT = DIV_COUNT_DEF
) (
    input  logic CLK,
    input  logic reset,
    output logic tick
);

    // DIV_COUNT==1 leaves a 1-bit counter pinned at 0, so tick stays high.
    localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clock_base_top.sv
// Rotating one-hot LED pattern; direction from a synchronised switch.
module clock_base_top
    import clock_base_pkg::*;
#(
    parameter int DIV_COUNT = DIV_COUNT_DEF,
    parameter logic [LED_W-1:0] LED_INIT = LED_INIT_DEF
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             sw,
    output logic [LED_W-1:0] Led
);

    logic             tick;
    logic             sw_meta_q, sw_meta_d;
    logic             sw_s_q, sw_s_d;
    logic [LED_W-1:0] led_q, led_d;

    tick_gen #(
        .DIV_COUNT(DIV_COUNT)
    ) u_tick_gen (
        .CLK  (CLK),
        .reset(reset),
        .tick (tick)
    );

    always_comb begin
        sw_meta_d = sw;
        sw_s_d = sw_meta_q;
        led_d = led_q;
        if (tick) begin
            if (sw_s_q) led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
            else        led_d = {led_q[0], led_q[LED_W-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= 1'b0;
            sw_s_q <= 1'b0;
            led_q <= LED_INIT;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_s_q <= sw_s_d;
            led_q <= led_d;
        end
    end

    assign Led = led_q;

endmodule

// File: tb/tb_clock_base_top.sv
// Directed bench: DIV_COUNT=4 instance plus a DIV_COUNT=1 instance.
module tb_clock_base_top;

    logic       clk;
    logic       reset_a, sw_a;
    logic       reset_b, sw_b;
    logic [7:0] led_a, led_b;
    logic [7:0] exp_a;
    logic       b_live;
    int         n_chk;
    int         n_fail;

    // After B's release the synchroniser still reads 0 for two edges,
    // so the first two shifts go right before the left rotation starts.
    logic [7:0] b_exp [12] = '{
        8'h80, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04,
        8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01
    };

    clock_base_top #(
        .DIV_COUNT(4),
        .LED_INIT (8'h01)
    ) dut_a (
        .CLK  (clk),
        .reset(reset_a),
        .sw   (sw_a),
        .Led  (led_a)
    );

    clock_base_top #(
        .DIV_COUNT(1),
        .LED_INIT (8'h01)
    ) dut_b (
        .CLK  (clk),
        .reset(reset_b),
        .sw   (sw_b),
        .Led  (led_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

    always @(negedge clk) begin
        if (b_live) chk("b_onehot", 32'($countones(led_b)), 32'd1);
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        b_live = 1'b0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        sw_a = 1'b1;
        sw_b = 1'b1;

        // 1: async reset between edges
        #2;
        reset_a = 1'b0;
        reset_b = 1'b0;
        #1;
        chk("rst_immediate", led_a, 8'h01);
        chk("rst_immediate_b", led_b, 8'h01);
        b_live = 1'b1;
        step(3);
        chk("rst_hold", led_a, 8'h01);

        // 2: left rotate, eight ticks back to 01
        reset_a = 1'b1;
        exp_a = 8'h01;
        step(3);
        chk("left_no_early", led_a, 8'h01);
        step(1);
        exp_a = rotl(exp_a);
        chk("left_first", led_a, exp_a);
        step(1);
        chk("left_hold", led_a, exp_a);
        step(3);
        for (int i = 2; i <= 8; i++) begin
            exp_a = rotl(exp_a);
            chk("left_tick", led_a, exp_a);
            if (i < 8) step(4);
        end
        chk("left_wrap", led_a, 8'h01);

        // 3: right rotate from 01
        sw_a = 1'b0;
        step(4);
        chk("right_1", led_a, 8'h80);
        step(4);
        chk("right_2", led_a, 8'h40);
        step(4);
        chk("right_3", led_a, 8'h20);

        // 4: direction change after reaching 08
        sw_a = 1'b1;
        reset_a = 1'b0;
        step(1);
        reset_a = 1'b1;
        step(4);
        chk("dir_l1", led_a, 8'h02);
        step(4);
        chk("dir_l2", led_a, 8'h04);
        step(4);
        chk("dir_l3", led_a, 8'h08);
        sw_a = 1'b0;
        step(4);
        chk("dir_r1", led_a, 8'h04);
        step(4);
        chk("dir_r2", led_a, 8'h02);

        // 5: reset at count==2 with Led==04
        sw_a = 1'b1;
        step(4);
        chk("mid_pre", led_a, 8'h04);
        step(2);
        chk("mid_cnt2", led_a, 8'h04);
        reset_a = 1'b0;
        #2;
        chk("mid_rst", led_a, 8'h01);
        reset_a = 1'b1;
        step(3);
        chk("mid_restart_hold", led_a, 8'h01);
        step(1);
        chk("mid_restart_shift", led_a, 8'h02);

        // 6: DIV_COUNT=1 shifts every edge
        reset_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("b_seq", led_b, b_exp[i]);
        end

        b_live = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
